// File: rtl/matmul_engine.sv
// Sequential N x N matrix multiplier: one multiply-accumulate per clock,
// results stored row-major into C_out, with a one-cycle done pulse at the end.
module matmul_engine #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode_signed,
  input  logic [N*N*DW-1:0]    A_in_flat,
  input  logic [N*N*DW-1:0]    B_in_flat,
  output logic                 busy,
  output logic                 done,
  output logic [N*N*CW-1:0]    C_out,
  output logic [CW-1:0]        mac_output
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [N*N*DW-1:0]     a_reg;
  logic [N*N*DW-1:0]     b_reg;
  logic                  mode_reg;
  logic [IW-1:0]         i_idx;
  logic [IW-1:0]         j_idx;
  logic [IW-1:0]         k_idx;
  logic [CW-1:0]         acc;

  logic [DW-1:0]         a_el;
  logic [DW-1:0]         b_el;
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]       prod_u;
  logic [CW-1:0]         prod_ext;

  // Both interpretations are formed at full 2*DW width; mode picks the extension.
  always_comb begin
    a_el     = a_reg[(int'(i_idx) * N + int'(k_idx)) * DW +: DW];
    b_el     = b_reg[(int'(k_idx) * N + int'(j_idx)) * DW +: DW];
    prod_s   = (2*DW)'($signed(a_el)) * (2*DW)'($signed(b_el));
    prod_u   = (2*DW)'(a_el) * (2*DW)'(b_el);
    prod_ext = mode_reg ? CW'(prod_s) : CW'(prod_u);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      i_idx    <= '0;
      j_idx    <= '0;
      k_idx    <= '0;
      acc      <= '0;
      C_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= A_in_flat;
            b_reg    <= B_in_flat;
            mode_reg <= mode_signed;
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            acc      <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc   <= acc + prod_ext;
          k_idx <= k_idx + IW'(1);
          if (k_idx == LAST) state <= STORE;
        end
        STORE: begin
          C_out[(int'(i_idx) * N + int'(j_idx)) * CW +: CW] <= acc;
          acc   <= '0;
          k_idx <= '0;
          if (j_idx == LAST) begin
            j_idx <= '0;
            if (i_idx == LAST) begin
              i_idx <= '0;
              state <= DONE;
            end else begin
              i_idx <= i_idx + IW'(1);
              state <= MAC;
            end
          end else begin
            j_idx <= j_idx + IW'(1);
            state <= MAC;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == MAC) || (state == STORE);
  assign done       = (state == DONE);
  assign mac_output = acc;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: directed and random jobs compared
// against a plain-arithmetic matrix product model.
module tb_matmul_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int AW = N*N*DW;
  localparam int RW = N*N*CW;
  localparam int LATENCY = N*N*(N+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode_signed = 1'b0;
  logic [AW-1:0] A_in_flat = '0;
  logic [AW-1:0] B_in_flat = '0;
  logic          busy;
  logic          done;
  logic [RW-1:0] C_out;
  logic [CW-1:0] mac_output;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_c [N*N];
  logic [CW-1:0] exp_first;

  matmul_engine #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_signed(mode_signed),
    .A_in_flat(A_in_flat), .B_in_flat(B_in_flat),
    .busy(busy), .done(done), .C_out(C_out), .mac_output(mac_output)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int elem(input logic [AW-1:0] m, input int r, input int c, input logic sgn);
    logic [DW-1:0] v;
    v = m[(r*N + c)*DW +: DW];
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  // Reference: textbook triple loop in integer arithmetic, truncated to CW bits.
  task automatic computeModel(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic sgn);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int sum = 0;
        for (int t = 0; t < N; t++) sum += elem(a, r, t, sgn) * elem(b, t, c, sgn);
        exp_c[r*N + c] = CW'(sum);
      end
    end
    exp_first = CW'(elem(a, 0, 0, sgn) * elem(b, 0, 0, sgn));
  endtask

  task automatic checkResult(input string tag);
    for (int e = 0; e < N*N; e++)
      checkOutput($sformatf("%s C[%0d][%0d]", tag, e / N, e % N), RW'(C_out[e*CW +: CW]), RW'(exp_c[e]));
  endtask

  task automatic waitDone(input string tag);
    int cnt = 0;
    while (cnt < 3*LATENCY) begin
      step();
      cnt++;
      if (done) break;
    end
    checkOutput({tag, " latency"}, RW'(cnt), RW'(LATENCY));
    checkOutput({tag, " busy with done"}, RW'(busy), RW'(0));
  endtask

  // Runs one job; when pulse_at > 0, start and scrambled inputs are applied for one cycle mid-job.
  task automatic applyStimulus(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic sgn, input int pulse_at);
    int cnt = 0;
    computeModel(a, b, sgn);
    A_in_flat = a;
    B_in_flat = b;
    mode_signed = sgn;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cnt < 3*LATENCY) begin
      step();
      cnt++;
      if (cnt == 1) checkOutput({tag, " first mac"}, RW'(mac_output), RW'(exp_first));
      if (cnt == pulse_at) begin
        start = 1'b1;
        A_in_flat = ~a;
        B_in_flat = ~b;
        mode_signed = ~sgn;
      end else if (cnt == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, RW'(cnt), RW'(LATENCY));
    checkOutput({tag, " busy with done"}, RW'(busy), RW'(0));
    checkResult(tag);
    step();
    checkOutput({tag, " done pulse width"}, RW'({busy, done}), RW'(0));
    step();
    step();
    checkOutput({tag, " C_out hold"}, C_out, {exp_c[15], exp_c[14], exp_c[13], exp_c[12],
                                              exp_c[11], exp_c[10], exp_c[9],  exp_c[8],
                                              exp_c[7],  exp_c[6],  exp_c[5],  exp_c[4],
                                              exp_c[3],  exp_c[2],  exp_c[1],  exp_c[0]});
  endtask

  function automatic logic [AW-1:0] randMatrix();
    logic [AW-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  function automatic logic [AW-1:0] fillMatrix(input logic [DW-1:0] v);
    logic [AW-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*DW +: DW] = v;
    return m;
  endfunction

  initial begin
    logic [AW-1:0] known_a, known_b, ident, ra, rb, rc, rd;
    known_a = 128'h02000104_02000301_08070605_04030201;
    known_b = 128'h01040000_01010202_02000104_03020001;
    ident = '0;
    for (int d = 0; d < N; d++) ident[(d*N + d)*DW +: DW] = DW'(1);

    step();
    step();
    checkOutput("reset busy", RW'(busy), RW'(0));
    checkOutput("reset done", RW'(done), RW'(0));
    checkOutput("reset C_out", C_out, RW'(0));
    checkOutput("reset mac_output", RW'(mac_output), RW'(0));
    reset = 1'b1;

    applyStimulus("known", known_a, known_b, 1'b0, 0);
    checkOutput("known C00", RW'(C_out[CW-1:0]), RW'(16'h000F));
    applyStimulus("identity", ident, known_b, 1'b0, 0);
    for (int e = 0; e < N*N; e++)
      checkOutput("identity vs B", RW'(C_out[e*CW +: CW]), RW'(known_b[e*DW +: DW]));

    applyStimulus("signed ff", fillMatrix(8'hFF), fillMatrix(8'h01), 1'b1, 0);
    checkOutput("signed ff C33", RW'(C_out[RW-1 -: CW]), RW'(16'hFFFC));
    applyStimulus("unsigned ff", fillMatrix(8'hFF), fillMatrix(8'h01), 1'b0, 0);
    checkOutput("unsigned ff C33", RW'(C_out[RW-1 -: CW]), RW'(16'h03FC));
    applyStimulus("wrap", fillMatrix(8'hFF), fillMatrix(8'hFF), 1'b0, 0);
    checkOutput("wrap C21", RW'(C_out[9*CW +: CW]), RW'(16'hF804));

    for (int r = 0; r < 6; r++) begin
      ra = randMatrix();
      rb = randMatrix();
      applyStimulus($sformatf("random%0d", r), ra, rb, 1'($urandom), 0);
    end

    ra = randMatrix();
    rb = randMatrix();
    applyStimulus("mid pulse", ra, rb, 1'b1, 23);

    // Start held high across a whole job, inputs changed while busy.
    ra = randMatrix();
    rb = randMatrix();
    rc = randMatrix();
    rd = randMatrix();
    A_in_flat = ra;
    B_in_flat = rb;
    mode_signed = 1'b0;
    start = 1'b1;
    step();
    A_in_flat = rc;
    B_in_flat = rd;
    computeModel(ra, rb, 1'b0);
    waitDone("held job1");
    checkResult("held job1");
    step();
    checkOutput("held idle gap", RW'({busy, done}), RW'(0));
    step();
    checkOutput("held job2 accepted", RW'(busy), RW'(1));
    start = 1'b0;
    computeModel(rc, rd, 1'b0);
    waitDone("held job2");
    checkResult("held job2");
    step();
    checkOutput("held no third job", RW'(busy), RW'(0));

    // Reset while accumulating element (1,2).
    ra = randMatrix();
    rb = randMatrix();
    A_in_flat = ra;
    B_in_flat = rb;
    mode_signed = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e < 6*(N+1) + 2; e++) step();
    checkOutput("pre-reset busy", RW'(busy), RW'(1));
    reset = 1'b0;
    start = 1'b1;
    step();
    checkOutput("midreset busy", RW'(busy), RW'(0));
    checkOutput("midreset done", RW'(done), RW'(0));
    checkOutput("midreset C_out", C_out, RW'(0));
    checkOutput("midreset mac_output", RW'(mac_output), RW'(0));
    start = 1'b0;
    reset = 1'b1;
    step();
    checkOutput("midreset stays idle", RW'(busy), RW'(0));
    ra = randMatrix();
    rb = randMatrix();
    applyStimulus("after reset", ra, rb, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (N x N, N >= 2).
REQ-002 SHALL have parameter DW, default 8, operand element width in bits.
REQ-003 SHALL have parameter CW, default 16, result element and accumulator width; CW >= 2*DW.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to begin a multiply.
REQ-007 SHALL have port mode_signed  input  1  1 = operands two's complement; 0 = unsigned.
REQ-008 SHALL have port A_in_flat  input  N*N*DW  matrix A; element (i,k) at bits [(i*N+k)*DW +: DW].
REQ-009 SHALL have port B_in_flat  input  N*N*DW  matrix B; element (k,j) at bits [(k*N+j)*DW +: DW].
REQ-010 SHALL have port busy  output  1  high from the cycle after start acceptance until done is asserted.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port C_out  output  N*N*CW  result; element (i,j) at bits [(i*N+j)*CW +: CW].
REQ-013 SHALL have port mac_output  output  CW  live accumulator value, for debug.

Function
REQ-014 SHALL implement states IDLE, MAC, STORE, DONE; encoding is free.
REQ-015 In IDLE, start=1 at a rising edge SHALL capture A_in_flat, B_in_flat and mode_signed into internal registers, zero i, j, k and the accumulator, and go to MAC.
REQ-016 Inputs SHALL NOT be sampled again until the next accepted start; changes while busy have no effect.
REQ-017 In MAC, each edge SHALL add A[i][k]*B[k][j] to the accumulator and increment k; on the edge with k = N-1, the next state SHALL be STORE.
REQ-018 Product SHALL be formed at 2*DW bits and extended to CW: signed mode sign-extends, unsigned mode zero-extends.
REQ-019 Accumulation SHALL be modulo 2^CW: wrap, no saturation, no overflow flag.
REQ-020 In STORE, one edge SHALL write the accumulator to C[i][j], clear the accumulator and k, and advance j; on j wrap (N-1 -> 0), i SHALL advance.
REQ-021 Elements SHALL be produced in row-major order: (0,0), (0,1), ... (N-1,N-1).
REQ-022 STORE of (N-1,N-1) SHALL go to DONE; every other STORE SHALL go to MAC.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-024 Latency: done SHALL be high in the cycle beginning N*N*(N+1) edges after the start-accepting edge; 80 edges for N=4.
REQ-025 busy SHALL be 1 in MAC and STORE and 0 in IDLE and DONE; done SHALL be 0 outside DONE.
REQ-026 start SHALL be ignored in MAC, STORE and DONE; there is no queueing.
REQ-027 C_out SHALL hold its last value through IDLE until the next job overwrites elements one by one; elements not yet stored keep their previous values.
REQ-028 mac_output SHALL equal the accumulator register at all times.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE and clear busy, done, C_out, mac_output, the internal A/B/mode registers and i, j, k to 0.
REQ-030 reset SHALL take priority over start and over any in-progress operation, including mid-MAC and in DONE.
REQ-031 After reset is released, the block SHALL accept start on the first edge with reset=1 and start=1.

Verification
REQ-032 Known data, N=4, DW=8, CW=16, unsigned: A=0x02000104_02000301_08070605_04030201, B=0x01040000_01010202_02000104_03020001, pulse start -> done exactly 80 edges later, C[0][0]=0x000F, all 16 elements match the golden model, busy low while done is high.
REQ-033 Identity: A=I, B=the B from REQ-032, unsigned -> C[i][j] equals zero-extended B[i][j] for all i, j.
REQ-034 Signedness: A all 0xFF, B all 0x01 -> signed mode every C element = 0xFFFC; unsigned mode every C element = 0x03FC.
REQ-035 Wrap: A and B all 0xFF, unsigned -> every C element = 0xF804.
REQ-036 Control corners:
- start held high for the whole job -> exactly one job, and a second job begins on the edge after DONE;
- start pulsed mid-job -> ignored;
- reset=0 during MAC of element (1,2) -> next cycle IDLE, busy=0, done=0, C_out=0, mac_output=0, and a subsequent start completes correctly.
